// File: rtl/uart_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit arbiter.
//   uart_arb_state_t     : arbiter FSM state encoding (ARB, HDR, STREAM)
//   UART_ID_BASE_DEFAULT : default base value of the source-ID header byte
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        HDR    = 2'd1,
        STREAM = 2'd2
    } uart_arb_state_t;

    localparam logic [7:0] UART_ID_BASE_DEFAULT = 8'h80;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the per-source byte streams and the transmitter byte port.
//   src_valid/src_data/src_last/src_ready : NUM_SRC producer streams
//                                           (source i on src_data[8i+7:8i])
//   tx_data_valid/tx_data/tx_data_ready   : single stream to the UART TX
// Modports:
//   master : the arbiter (accepts sources, offers bytes to the transmitter)
//   slave  : the environment (producers plus transmitter)
//
// Handshake: a byte moves when valid and ready are both high on a rising clk
// edge. A producer holds valid and its data/last stable until that edge;
// ready may be high with valid low, which means nothing. The arbiter keeps
// tx_data stable while tx_data_valid=1 and tx_data_ready=0 as long as the
// granted source holds its byte.
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC*8-1:0] src_data;
    logic [NUM_SRC-1:0]   src_last;
    logic [NUM_SRC-1:0]   src_ready;
    logic                 tx_data_valid;
    logic [7:0]           tx_data;
    logic                 tx_data_ready;

    modport master (
        input  src_valid, src_data, src_last, tx_data_ready,
        output src_ready, tx_data_valid, tx_data
    );

    modport slave (
        output src_valid, src_data, src_last, tx_data_ready,
        input  src_ready, tx_data_valid, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_counter.sv
// ----------------------------------------------------------------------------
// counter
// Free-running up counter with synchronous load.
//   clk, rst_n : clock, asynchronous active-low reset (q -> 0)
//   en         : increment by one
//   load       : load load_val (wins over en)
//   q          : count value
// ----------------------------------------------------------------------------
module counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index of the last winner; scanning starts at ptr+1
//   gnt_idx : index of the first request found at ptr+1, ptr+2, ... mod N
//   gnt_any : at least one request is set
// The request vector is rotated so that position 0 is ptr+1, then the lowest
// set bit of the rotated vector is mapped back to a source index.
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [N-1:0] rot;

    always_comb begin
        int idx;
        idx     = 0;
        rot     = '0;
        gnt_idx = '0;
        gnt_any = |req;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + 1 + k;
            if (idx >= N) idx = idx - N;
            rot[k] = req[IW'(idx)];
        end
        // Scan downwards so the lowest rotated position is the last to write.
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                idx = int'(ptr) + 1 + j;
                if (idx >= N) idx = idx - N;
                gnt_idx = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one 8N1 UART transmitter between NUM_SRC byte-stream producers.
// Grants are round-robin and last for a whole message (until the byte
// flagged src_last is accepted). With INSERT_ID=1 each message is preceded
// by the header byte ID_BASE+grant_id. With IDLE_TIMEOUT>0 a grant whose
// source stays idle that many STREAM cycles is dropped with an abort pulse.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : sources and transmitter port (uart_tx_arbiter_if.master)
//   grant_valid : a source owns the link (HDR or STREAM)
//   grant_id    : owning source; holds its last value while idle
//   abort       : one-cycle pulse when a grant is released by timeout
//   state_dbg   : current FSM state
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int         NUM_SRC      = 4,
    parameter  int         INSERT_ID    = 1,
    parameter  logic [7:0] ID_BASE      = UART_ID_BASE_DEFAULT,
    parameter  int         IDLE_TIMEOUT = 0,
    localparam int         GW           = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_tx_arbiter_if.master       bus,
    output logic                    grant_valid,
    output logic [GW-1:0]           grant_id,
    output logic                    abort,
    output uart_arb_state_t         state_dbg
);

    // Abort fires in the stall cycle that would make the count reach
    // IDLE_TIMEOUT, so compare against one less.
    localparam logic [15:0] TO_LAST = (IDLE_TIMEOUT > 0) ? 16'(IDLE_TIMEOUT - 1) : 16'd0;

    uart_arb_state_t state_q, state_d;
    logic [GW-1:0]   gid_q, gid_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   pick_idx;
    logic            pick_any;
    logic [15:0]     idle_cnt;
    logic            cnt_load, cnt_en;
    logic            g_valid, g_last;
    logic [7:0]      g_data;

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req     (bus.src_valid),
        .ptr     (rr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    counter #(.WIDTH(16)) u_idle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (cnt_en),
        .load     (cnt_load),
        .load_val (16'd0),
        .q        (idle_cnt)
    );

    assign g_valid = bus.src_valid[gid_q];
    assign g_last  = bus.src_last[gid_q];
    assign g_data  = bus.src_data[{gid_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            gid_q   <= '0;
            rr_q    <= GW'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        gid_d             = gid_q;
        rr_d              = rr_q;
        bus.src_ready     = '0;
        bus.tx_data_valid = 1'b0;
        bus.tx_data       = 8'h00;
        abort             = 1'b0;
        cnt_load          = 1'b0;
        cnt_en            = 1'b0;
        case (state_q)
            ARB: begin
                // Holding the count at zero outside STREAM clears it on entry.
                cnt_load = 1'b1;
                if (pick_any) begin
                    gid_d   = pick_idx;
                    state_d = (INSERT_ID != 0) ? HDR : STREAM;
                end
            end
            HDR: begin
                cnt_load          = 1'b1;
                bus.tx_data_valid = 1'b1;
                bus.tx_data       = ID_BASE + 8'(gid_q);
                if (bus.tx_data_ready) state_d = STREAM;
            end
            STREAM: begin
                bus.tx_data_valid     = g_valid;
                bus.tx_data           = g_data;
                bus.src_ready[gid_q]  = bus.tx_data_ready;
                if (g_valid) begin
                    cnt_load = 1'b1;
                    if (bus.tx_data_ready && g_last) begin
                        rr_d    = gid_q;
                        state_d = ARB;
                    end
                end else if (IDLE_TIMEOUT > 0) begin
                    if (idle_cnt == TO_LAST) begin
                        abort   = 1'b1;
                        rr_d    = gid_q;
                        state_d = ARB;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign grant_valid = (state_q != ARB);
    assign grant_id    = gid_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NUM_SRC=4, INSERT_ID=1,
// ID_BASE=8'h80, IDLE_TIMEOUT=5). A cycle table checks outputs directly;
// hand-written sequences drive per-source message buffers while a scoreboard
// of expected transmitter bytes is popped on each tx transfer.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic            abort;
    uart_arb_state_t state_dbg;

    uart_tx_arbiter_if #(.NUM_SRC(NS)) bus ();

    uart_tx_arbiter #(
        .NUM_SRC      (NS),
        .INSERT_ID    (1),
        .ID_BASE      (8'h80),
        .IDLE_TIMEOUT (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .abort       (abort),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int           checks   = 0;
    int           failures = 0;
    logic [7:0]   exp_q[$];
    logic [1:0]   grant_log[$];
    logic         prev_gv;
    logic [8:0]   sbuf[NS][32];
    int           rd[NS];
    int           wr[NS];
    logic [NS-1:0] src_en;
    logic         tx_rdy;

    typedef struct {
        logic [3:0]      valid;
        logic [3:0]      last;
        logic [31:0]     data;
        logic            rdy;
        uart_arb_state_t e_state;
        logic            e_tv;
        logic [7:0]      e_td;
        logic [3:0]      e_sr;
        logic            e_gv;
        logic [1:0]      e_gid;
    } vec_t;

    vec_t vecs[15];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input int s, input logic [7:0] d, input logic last);
        sbuf[s][wr[s]] = {last, d};
        wr[s]++;
    endtask

    task automatic drive_from_bufs();
        for (int i = 0; i < NS; i++) begin
            if (src_en[i] && rd[i] < wr[i]) begin
                bus.src_valid[i]        = 1'b1;
                bus.src_data[8*i +: 8]  = sbuf[i][rd[i]][7:0];
                bus.src_last[i]         = sbuf[i][rd[i]][8];
            end else begin
                bus.src_valid[i]        = 1'b0;
                bus.src_data[8*i +: 8]  = 8'h00;
                bus.src_last[i]         = 1'b0;
            end
        end
        bus.tx_data_ready = tx_rdy;
    endtask

    // Called just before the rising edge: outputs are settled.
    task automatic sample();
        logic [7:0] e;
        check("src_ready_onehot0", 32'($countones(bus.src_ready) <= 1), 1);
        if (bus.tx_data_valid && bus.tx_data_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected: got 0x%0h expected no byte at %0t", bus.tx_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", {24'h0, bus.tx_data}, {24'h0, e});
            end
        end
        if (grant_valid && !prev_gv) grant_log.push_back(grant_id);
        prev_gv = grant_valid;
        for (int i = 0; i < NS; i++) begin
            if (bus.src_valid[i] && bus.src_ready[i] && rd[i] < wr[i]) rd[i]++;
        end
    endtask

    task automatic cycle();
        drive_from_bufs();
        #4;
        sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_en = '1;
        tx_rdy = 1'b1;
        for (int i = 0; i < NS; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        bus.src_valid     = '0;
        bus.src_data      = '0;
        bus.src_last      = '0;
        bus.tx_data_ready = 1'b1;
        exp_q.delete();
        grant_log.delete();
        prev_gv = 1'b0;
        #1;
        check("rst_state", 32'(state_dbg), 32'(ARB));
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_abort", 32'(abort), 0);
        check("rst_tx_valid", 32'(bus.tx_data_valid), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_src_ready", 32'(bus.src_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            cycle();
            n++;
            busy = (exp_q.size() != 0) || (state_dbg != ARB);
            for (int i = 0; i < NS; i++) if (src_en[i] && rd[i] < wr[i]) busy = 1'b1;
        end
        check(name, 32'(busy), 0);
    endtask

    task automatic check_grants(input string name, input logic [1:0] e0, input logic [1:0] e1);
        check({name, "_count"}, grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check({name, "_g0"}, 32'(grant_log[0]), 32'(e0));
            check({name, "_g1"}, 32'(grant_log[1]), 32'(e1));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- main ----------------
    initial begin
        int bad;
        int gcount;

        // Cycle table: src0 two-byte message, src3 with ready stalls in HDR
        // and STREAM, src1 requesting in the cycle src3's last byte goes.
        vecs[0]  = '{4'h1, 4'h0, 32'h0000_0041, 1'b1, ARB,    1'b0, 8'h00, 4'h0, 1'b0, 2'd0};
        vecs[1]  = '{4'h1, 4'h0, 32'h0000_0041, 1'b1, HDR,    1'b1, 8'h80, 4'h0, 1'b1, 2'd0};
        vecs[2]  = '{4'h1, 4'h0, 32'h0000_0041, 1'b1, STREAM, 1'b1, 8'h41, 4'h1, 1'b1, 2'd0};
        vecs[3]  = '{4'h1, 4'h1, 32'h0000_0042, 1'b1, STREAM, 1'b1, 8'h42, 4'h1, 1'b1, 2'd0};
        vecs[4]  = '{4'h0, 4'h0, 32'h0000_0000, 1'b1, ARB,    1'b0, 8'h00, 4'h0, 1'b0, 2'd0};
        vecs[5]  = '{4'h0, 4'h0, 32'h0000_0000, 1'b0, ARB,    1'b0, 8'h00, 4'h0, 1'b0, 2'd0};
        vecs[6]  = '{4'h8, 4'h8, 32'h3300_0000, 1'b0, ARB,    1'b0, 8'h00, 4'h0, 1'b0, 2'd0};
        vecs[7]  = '{4'h8, 4'h8, 32'h3300_0000, 1'b0, HDR,    1'b1, 8'h83, 4'h0, 1'b1, 2'd3};
        vecs[8]  = '{4'h8, 4'h8, 32'h3300_0000, 1'b1, HDR,    1'b1, 8'h83, 4'h0, 1'b1, 2'd3};
        vecs[9]  = '{4'h8, 4'h8, 32'h3300_0000, 1'b0, STREAM, 1'b1, 8'h33, 4'h0, 1'b1, 2'd3};
        vecs[10] = '{4'hA, 4'h8, 32'h3300_1100, 1'b1, STREAM, 1'b1, 8'h33, 4'h8, 1'b1, 2'd3};
        vecs[11] = '{4'h2, 4'h2, 32'h0000_1100, 1'b1, ARB,    1'b0, 8'h00, 4'h0, 1'b0, 2'd3};
        vecs[12] = '{4'h2, 4'h2, 32'h0000_1100, 1'b1, HDR,    1'b1, 8'h81, 4'h0, 1'b1, 2'd1};
        vecs[13] = '{4'h2, 4'h2, 32'h0000_1100, 1'b1, STREAM, 1'b1, 8'h11, 4'h2, 1'b1, 2'd1};
        vecs[14] = '{4'h0, 4'h0, 32'h0000_0000, 1'b1, ARB,    1'b0, 8'h00, 4'h0, 1'b0, 2'd1};

        do_reset();
        exp_q = '{8'h80, 8'h41, 8'h42, 8'h83, 8'h33, 8'h81, 8'h11};
        for (int r = 0; r < 15; r++) begin
            bus.src_valid     = vecs[r].valid;
            bus.src_last      = vecs[r].last;
            bus.src_data      = vecs[r].data;
            bus.tx_data_ready = vecs[r].rdy;
            #4;
            check($sformatf("vec%0d_state", r), 32'(state_dbg), 32'(vecs[r].e_state));
            check($sformatf("vec%0d_tx_valid", r), 32'(bus.tx_data_valid), 32'(vecs[r].e_tv));
            check($sformatf("vec%0d_tx_data", r), 32'(bus.tx_data), 32'(vecs[r].e_td));
            check($sformatf("vec%0d_src_ready", r), 32'(bus.src_ready), 32'(vecs[r].e_sr));
            check($sformatf("vec%0d_grant_valid", r), 32'(grant_valid), 32'(vecs[r].e_gv));
            check($sformatf("vec%0d_grant_id", r), 32'(grant_id), 32'(vecs[r].e_gid));
            check($sformatf("vec%0d_abort", r), 32'(abort), 0);
            sample();
            @(negedge clk);
        end
        check("vec_exp_drained", exp_q.size(), 0);

        // src1 and src3 each request a one-byte message from reset.
        do_reset();
        push_byte(1, 8'h11, 1'b1);
        push_byte(3, 8'h33, 1'b1);
        exp_q = '{8'h81, 8'h11, 8'h83, 8'h33};
        run_until_idle("two_src_done", 40);
        check_grants("two_src", 2'd1, 2'd3);

        // src0 and src2 two messages each; src2 starts requesting mid-message.
        do_reset();
        push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b1);
        push_byte(0, 8'h03, 1'b0); push_byte(0, 8'h04, 1'b1);
        push_byte(2, 8'h21, 1'b0); push_byte(2, 8'h22, 1'b1);
        push_byte(2, 8'h23, 1'b0); push_byte(2, 8'h24, 1'b1);
        exp_q = '{8'h80, 8'h01, 8'h02, 8'h82, 8'h21, 8'h22,
                  8'h80, 8'h03, 8'h04, 8'h82, 8'h23, 8'h24};
        src_en[2] = 1'b0;
        cycle(); cycle(); cycle();
        src_en[2] = 1'b1;
        run_until_idle("rr_order_done", 80);
        check("rr_order_count", grant_log.size(), 4);
        gcount = grant_log.size();
        for (int k = 0; k < gcount && k < 4; k++)
            check($sformatf("rr_order_g%0d", k), 32'(grant_log[k]), (k % 2 == 0) ? 0 : 2);

        // Transmitter stalls 20 cycles in STREAM, then the source idles briefly.
        do_reset();
        push_byte(1, 8'h51, 1'b0); push_byte(1, 8'h52, 1'b0); push_byte(1, 8'h53, 1'b1);
        exp_q = '{8'h81, 8'h51, 8'h52, 8'h53};
        cycle(); cycle(); cycle();
        tx_rdy = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            drive_from_bufs();
            #4;
            if (!(bus.tx_data_valid && bus.tx_data == 8'h52 && bus.src_ready == 4'h0)) bad++;
            sample();
            @(negedge clk);
        end
        check("stall_hold_bad_cycles", bad, 0);
        tx_rdy = 1'b1;
        cycle();
        src_en[1] = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            drive_from_bufs();
            #4;
            if (!(grant_valid && !bus.tx_data_valid && !abort && grant_id == 2'd1)) bad++;
            sample();
            @(negedge clk);
        end
        check("src_gap_bad_cycles", bad, 0);
        src_en[1] = 1'b1;
        run_until_idle("stall_done", 40);

        // Idle timeout: src1 stalls after its header while src2 waits.
        do_reset();
        push_byte(1, 8'h61, 1'b0); push_byte(1, 8'h62, 1'b1);
        push_byte(2, 8'h71, 1'b0); push_byte(2, 8'h72, 1'b1);
        exp_q = '{8'h81, 8'h82, 8'h71, 8'h72};
        cycle();
        src_en[1] = 1'b0;
        cycle();
        for (int k = 1; k <= 5; k++) begin
            drive_from_bufs();
            #4;
            check($sformatf("timeout_abort_stall%0d", k), 32'(abort), 32'(k == 5));
            sample();
            @(negedge clk);
        end
        drive_from_bufs();
        #4;
        check("timeout_after_state", 32'(state_dbg), 32'(ARB));
        check("timeout_after_abort", 32'(abort), 0);
        check("timeout_after_grant_valid", 32'(grant_valid), 0);
        sample();
        @(negedge clk);
        drive_from_bufs();
        #4;
        check("timeout_next_state", 32'(state_dbg), 32'(HDR));
        check("timeout_next_grant_id", 32'(grant_id), 2);
        check("timeout_next_tx_data", 32'(bus.tx_data), 32'h82);
        sample();
        @(negedge clk);
        rd[1] = wr[1];
        run_until_idle("timeout_done", 40);
        check_grants("timeout", 2'd1, 2'd2);

        // Asynchronous reset in the middle of a STREAM.
        do_reset();
        push_byte(2, 8'hA1, 1'b0); push_byte(2, 8'hA2, 1'b0); push_byte(2, 8'hA3, 1'b1);
        exp_q = '{8'h82, 8'hA1};
        cycle(); cycle(); cycle();
        drive_from_bufs();
        #1;
        check("pre_rst_tx_valid", 32'(bus.tx_data_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx_valid", 32'(bus.tx_data_valid), 0);
        check("async_rst_src_ready", 32'(bus.src_ready), 0);
        check("async_rst_grant_valid", 32'(grant_valid), 0);
        check("async_rst_state", 32'(state_dbg), 32'(ARB));
        check("async_rst_exp_drained", exp_q.size(), 0);
        @(negedge clk);
        do_reset();
        push_byte(3, 8'h3C, 1'b1);
        push_byte(0, 8'h0C, 1'b1);
        exp_q = '{8'h80, 8'h0C, 8'h83, 8'h3C};
        run_until_idle("post_rst_done", 40);
        check_grants("post_rst", 2'd0, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
